// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Optional macro DIV_ZERO_FLAG_EN adds a div_zero output marking results produced by the divisor==0 path.
module seq_divider #(
   parameter int unsigned DW = 16,
   parameter int unsigned VW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          done_flag,
   output logic          busy
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic          div_zero
`endif
);

   localparam int unsigned CW = $clog2(DW + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] dvd_q, dvd_d;
   logic [VW:0]   pr_q, pr_d;
   logic [VW-1:0] dvs_q, dvs_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [VW-1:0] rem_q, rem_d;
   logic [VW+1:0] shifted;
   logic [VW:0]   diff;
   logic          fits;
`ifdef DIV_ZERO_FLAG_EN
   logic          dz_q, dz_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = (divisor == '0) ? DONE : CALC;
         CALC: if (cnt_q == CW'(1)) state_d = DONE;
         DONE: if (!start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Partial remainder stays below the divisor, so the top shifted bit is always 0; keeping it makes the compare width-safe.
   always_comb begin
      shifted = {pr_q, dvd_q[DW-1]};
      fits    = shifted >= {2'b00, dvs_q};
      diff    = shifted[VW:0] - {1'b0, dvs_q};
      dvd_d   = dvd_q;
      pr_d    = pr_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
`ifdef DIV_ZERO_FLAG_EN
      dz_d    = dz_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  dvd_d = dividend;
                  dvs_d = divisor;
                  pr_d  = '0;
                  cnt_d = CW'(DW);
               end else begin
                  quo_d = '1;
                  rem_d = dividend[VW-1:0];
`ifdef DIV_ZERO_FLAG_EN
                  dz_d  = 1'b1;
`endif
               end
            end
         end
         CALC: begin
            pr_d  = fits ? diff : shifted[VW:0];
            dvd_d = {dvd_q[DW-2:0], fits};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               quo_d = dvd_d;
               rem_d = pr_d[VW-1:0];
`ifdef DIV_ZERO_FLAG_EN
               dz_d  = 1'b0;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dvd_q <= '0;
         pr_q  <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
`ifdef DIV_ZERO_FLAG_EN
         dz_q  <= 1'b0;
`endif
      end else begin
         dvd_q <= dvd_d;
         pr_q  <= pr_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
`ifdef DIV_ZERO_FLAG_EN
         dz_q  <= dz_d;
`endif
      end
   end

   always_comb begin
      done_flag = (state_q == DONE);
      busy      = (state_q == CALC);
      quotient  = quo_q;
      remainder = rem_q;
`ifdef DIV_ZERO_FLAG_EN
      div_zero  = dz_q;
`endif
   end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic (/ and %) reference model.
// Honours DIV_ZERO_FLAG_EN to also check the div_zero output.
module tb_seq_divider;

   localparam int unsigned DW = 16;
   localparam int unsigned VW = 8;

   logic          clk;
   logic          rst;
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          done_flag;
   logic          busy;
`ifdef DIV_ZERO_FLAG_EN
   logic          div_zero;
   logic          exp_dz;
`endif

   int unsigned n_checks;
   int unsigned n_errs;

   seq_divider #(.DW(DW), .VW(VW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .done_flag (done_flag),
      .busy      (busy)
`ifdef DIV_ZERO_FLAG_EN
      ,
      .div_zero  (div_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division; divide-by-zero yields all ones and the dividend's low byte.
   function automatic logic [DW+VW-1:0] ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b);
      int unsigned q, r;
      if (b == 0) begin
         q = (1 << DW) - 1;
         r = a % (1 << VW);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {DW'(q), VW'(r)};
   endfunction

   task automatic check_cleared(input string tag);
      check_eq({tag, "_q"},    32'(quotient), 32'h0);
      check_eq({tag, "_r"},    32'(remainder), 32'h0);
      check_eq({tag, "_done"}, 32'(done_flag), 32'h0);
      check_eq({tag, "_busy"}, 32'(busy), 32'h0);
`ifdef DIV_ZERO_FLAG_EN
      check_eq({tag, "_dz"},   32'(div_zero), 32'h0);
`endif
   endtask

   // One full transaction; abort_at >= 0 pulses reset at that many cycles after acceptance.
   task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                          input bit hold, input bit corrupt, input int abort_at);
      logic [DW+VW-1:0] exp;
      int unsigned      busy_cnt;
      int unsigned      lat;
      bit               seen;
      exp      = ref_div(a, b);
      busy_cnt = 0;
      lat      = 0;
      seen     = 0;
      @(negedge clk);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clk);
      for (int i = 0; i < int'(DW) + 8; i++) begin
         @(negedge clk);
         if (abort_at == i) begin
            rst   = 1'b0;
            start = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            check_cleared("abort");
`ifdef DIV_ZERO_FLAG_EN
            exp_dz = 1'b0;
`endif
            return;
         end
         if (corrupt && i == 5) begin
            dividend = 16'hFFFF;
            divisor  = 8'($urandom);
         end
         if (done_flag) begin
            lat  = i + 1;
            seen = 1;
            if (!hold) start = 1'b0;
            break;
         end
         if (busy) busy_cnt++;
         if (!hold) start = 1'b0;
      end
      check_eq("done_seen", 32'(seen), 32'h1);
      check_eq("latency",   lat, (b == 0) ? 32'd1 : 32'(DW + 1));
      check_eq("busy_cyc",  busy_cnt, (b == 0) ? 32'd0 : 32'(DW));
      check_eq("quotient",  32'(quotient), 32'(exp[DW+VW-1:VW]));
      check_eq("remainder", 32'(remainder), 32'(exp[VW-1:0]));
`ifdef DIV_ZERO_FLAG_EN
      exp_dz = (b == 0);
      check_eq("div_zero",  32'(div_zero), 32'(exp_dz));
`endif
      if (hold) begin
         repeat (3) begin
            @(negedge clk);
            check_eq("done_hold", 32'(done_flag), 32'h1);
         end
         start = 1'b0;
      end
      @(negedge clk);
      check_eq("done_drop", 32'(done_flag), 32'h0);
      check_eq("q_held",    32'(quotient), 32'(exp[DW+VW-1:VW]));
      check_eq("r_held",    32'(remainder), 32'(exp[VW-1:0]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errs   = 0;
      rst      = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
`ifdef DIV_ZERO_FLAG_EN
      exp_dz   = 1'b0;
`endif
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      check_cleared("reset");
      repeat (10) begin
         @(negedge clk);
         check_eq("idle_done", 32'(done_flag), 32'h0);
         check_eq("idle_busy", 32'(busy), 32'h0);
      end

      run_div(16'h0993, 8'h13, 1'b1, 1'b0, -1);
      run_div(16'h31B1, 8'h35, 1'b0, 1'b1, -1);
      run_div(16'hFFFF, 8'h01, 1'b0, 1'b0, -1);
      run_div(16'hFFFF, 8'hFF, 1'b1, 1'b0, -1);
      run_div(16'h0005, 8'h09, 1'b0, 1'b0, -1);
      run_div(16'h1234, 8'h00, 1'b0, 1'b0, -1);
      run_div(16'h0993, 8'h13, 1'b0, 1'b0, -1);
      run_div(16'h0993, 8'h13, 1'b1, 1'b0, 8);
      run_div(16'h0993, 8'h13, 1'b0, 1'b0, -1);
      run_div(16'h1234, 8'h00, 1'b1, 1'b0, -1);

      for (int n = 0; n < 40; n++) begin
         logic [DW-1:0] a;
         logic [VW-1:0] b;
         int unsigned   sel;
         a   = DW'($urandom);
         sel = $urandom_range(0, 9);
         case (sel)
            0: b = '0;
            1: b = 8'h01;
            2: b = 8'hFF;
            default: b = VW'($urandom);
         endcase
         run_div(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential restoring shift-subtract divider. It is the inverse companion of the team's 8x8 sequential multiplier: it takes a 16-bit dividend and an 8-bit divisor and returns the quotient and remainder.
- Uses the same start/done_flag level handshake as the multiplier, so the top-level controller drives either unit identically.
- Output feeds the same result/7-segment path as the multiplier's d_out.

Parameters:
- DW, 16, dividend and quotient width in bits (must be >= VW).
- VW, 8, divisor and remainder width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  level request; sampled only in IDLE.
- dividend  input  DW  numerator; captured on the accepting edge.
- divisor  input  VW  denominator; captured on the accepting edge.
- quotient  output  DW  registered result.
- remainder  output  VW  registered result.
- done_flag  output  1  high while in DONE.
- busy  output  1  high while in CALC.

Behaviour:
- Reset: the design has one clock, clk. Reset is rst, synchronous and active-low: rst=0 at a rising edge of clk puts the block in IDLE and clears all registers. quotient=0, remainder=0, done_flag=0, busy=0, and the iteration counter is 0.
- Reset mid-operation (in CALC or DONE) aborts the divide. No partial result is ever presented.
- States: IDLE, CALC, DONE (2-bit encoding).
- IDLE, start=1, divisor!=0:
  - Latch dividend into the shift register and divisor into the divisor register.
  - Clear the partial remainder (VW+1 bits) and load the counter with DW.
  - Go to CALC.
- IDLE, start=1, divisor==0:
  - Go directly to DONE.
  - quotient <= all ones, remainder <= dividend[VW-1:0].
- IDLE, start=0: hold.
- CALC, one iteration per clock:
  - Shift {partial remainder, dividend reg} left by 1.
  - If the shifted partial remainder >= divisor: subtract the divisor and set the new quotient LSB to 1. Otherwise set it to 0.
  - Decrement the counter.
  - When the counter reaches 1 on this edge (last iteration), load quotient and remainder from the final values and go to DONE.
- Latency: if start is accepted at edge k, done_flag rises after edge k+DW (16 CALC cycles for the default). Divide-by-zero case: done_flag rises after edge k+1.
- DONE:
  - done_flag=1; quotient and remainder are stable.
  - Stay in DONE while start=1. Go to IDLE on the first edge with start=0.
  - A continuously held start therefore never retriggers.
- busy=1 only in CALC.
- Changes on dividend or divisor after the accepting edge are ignored until the next acceptance.
- quotient and remainder hold their last values through IDLE. They change only on entry to DONE.
- Width rules:
  - The partial remainder is VW+1 bits so the compare/subtract cannot overflow.
  - The final remainder is < divisor and fits in VW bits.
  - The quotient can reach all ones (e.g. divisor=1).
- start rising and rst=0 on the same edge: reset wins.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined: adds an output port div_zero (1 bit), reset 0.
  - Set on entry to DONE from the divisor==0 path; cleared on entry to DONE from the CALC path.
  - Holds between operations like quotient.
- Undefined: no div_zero port. The divide-by-zero result (all-ones quotient, dividend low bits as remainder) is unchanged.

Test Plan:
- rst low 1 cycle, then high -> quotient=0x0000, remainder=0x00, done_flag=0, busy=0. Hold start=0 for 10 cycles -> state stays IDLE.
- dividend=0x0993, divisor=0x13, start held high -> busy=1 for 16 cycles. done_flag rises after edge k+16 with quotient=0x0081, remainder=0x00. done_flag stays high while start=1 and drops 1 cycle after start=0.
- dividend=0x31B1, divisor=0x35 -> quotient=0x00F0, remainder=0x01. Change dividend to 0xFFFF mid-CALC -> result unaffected.
- Boundary cases:
  - 0xFFFF/0x01 -> quotient=0xFFFF, remainder=0x00.
  - 0xFFFF/0xFF -> quotient=0x0101, remainder=0x00.
  - 0x0005/0x09 -> quotient=0x0000, remainder=0x05.
- Divide by zero: dividend=0x1234, divisor=0x00 -> done_flag after 1 edge, busy never high, quotient=0xFFFF, remainder=0x34. With DIV_ZERO_FLAG_EN, div_zero=1, then 0 after a following valid divide.
- rst=0 at CALC iteration 8 of 0x0993/0x13 -> next cycle IDLE, all outputs 0. A restart produces the correct 0x0081/0x00 result.
